spi_sclk_engine: RTL and testbench



---
 rtl/spi_sclk_engine_if.sv | 34 +++
 rtl/spi_sclk_engine.sv | 104 ++++++++++
 tb/tb_spi_sclk_engine.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/spi_sclk_engine_if.sv
// ============================================================================
// Module      : spi_sclk_engine_if
// Description : Control and strobe bundle between the SPI controller and
//               its serial-clock engine.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface spi_sclk_engine_if;
    logic       i_mode;
    logic       i_cpol;
    logic       i_cpha;
    logic [2:0] i_div;
    logic       i_cs;
    logic       i_ext_sclk;
    logic       o_sclk;
    logic       o_sclk_oe;
    logic       o_sclk_pe;
    logic       o_sclk_ne;
    logic       o_shift_stb;
    logic       o_sample_stb;

    modport slave (
        input  i_mode, i_cpol, i_cpha, i_div, i_cs, i_ext_sclk,
        output o_sclk, o_sclk_oe, o_sclk_pe, o_sclk_ne, o_shift_stb, o_sample_stb
    );

    modport master (
        output i_mode, i_cpol, i_cpha, i_div, i_cs, i_ext_sclk,
        input  o_sclk, o_sclk_oe, o_sclk_pe, o_sclk_ne, o_shift_stb, o_sample_stb
    );
endinterface

`default_nettype wire

// File: rtl/spi_sclk_engine.sv
// ============================================================================
// Module      : spi_sclk_engine
// Description : SPI SCLK generator (leader) and edge/shift/sample strobe
//               generator for either the internal or external SCLK.
//               Optional macro SCLK_SYNC_EN adds a second sampling flop.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_sclk_engine #(
    parameter int CNT_W = 7
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    spi_sclk_engine_if.slave    bus
);

    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_div;
    logic             r_cpol;
    logic             r_sclk;
    logic [CNT_W-1:0] w_limit;

    // Divider and polarity are only captured while idle so a frame never
    // sees a mid-transfer change of timing or edge ordering.
    assign w_limit = (CNT_W'(1) << r_div) - CNT_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_div  <= '0;
            r_cpol <= 1'b0;
            r_sclk <= 1'b0;
        end else if (bus.i_cs) begin
            r_cnt  <= '0;
            r_div  <= bus.i_div;
            r_cpol <= bus.i_cpol;
            r_sclk <= bus.i_cpol;
        end else if (r_cnt == w_limit) begin
            r_cnt  <= '0;
            r_sclk <= ~r_sclk;
        end else begin
            r_cnt  <= r_cnt + CNT_W'(1);
        end
    end

    logic w_src;
    logic w_src_s;
    logic r_s1;
    logic r_prev;

    assign w_src = bus.i_mode ? r_sclk : bus.i_ext_sclk;

`ifdef SCLK_SYNC_EN
    logic r_s2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1   <= 1'b0;
            r_s2   <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_s1   <= w_src;
            r_s2   <= r_s1;
            r_prev <= r_s2;
        end
    end

    assign w_src_s = r_s2;
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1   <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_s1   <= w_src;
            r_prev <= w_src_s;
        end
    end

    assign w_src_s = r_s1;
`endif

    logic w_pe;
    logic w_ne;
    logic w_lead;
    logic w_trail;

    // Gating with cs hides the idle-level step seen right after reset.
    assign w_pe    =  w_src_s & ~r_prev & ~bus.i_cs;
    assign w_ne    = ~w_src_s &  r_prev & ~bus.i_cs;
    assign w_lead  = r_cpol ? w_ne : w_pe;
    assign w_trail = r_cpol ? w_pe : w_ne;

    assign bus.o_sclk       = r_sclk;
    assign bus.o_sclk_oe    = bus.i_mode;
    assign bus.o_sclk_pe    = w_pe;
    assign bus.o_sclk_ne    = w_ne;
    assign bus.o_shift_stb  = bus.i_cpha ? w_lead  : w_trail;
    assign bus.o_sample_stb = bus.i_cpha ? w_trail : w_lead;

endmodule

`default_nettype wire

// File: tb/tb_spi_sclk_engine.sv
// ============================================================================
// Module      : tb_spi_sclk_engine
// Description : Directed, table-driven bench for spi_sclk_engine (default
//               build, SCLK_SYNC_EN undefined).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spi_sclk_engine;

    logic clk;
    logic rst_n;

    spi_sclk_engine_if bus ();

    spi_sclk_engine #(.CNT_W(7)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic       mode;
        logic       cpol;
        logic       cpha;
        logic [2:0] div;
        logic       cs;
        logic       ext;
        logic       e_sclk;
        logic       c_sclk;
        logic       e_pe;
        logic       e_ne;
        logic       e_shift;
        logic       e_sample;
    } row_t;

    int n_checks = 0;
    int n_fail   = 0;
    row_t rows[$];

    function automatic row_t mk(input logic mode, input logic cpol, input logic cpha,
                                input logic [2:0] div, input logic cs, input logic ext,
                                input logic e_sclk, input logic c_sclk,
                                input logic e_pe, input logic e_ne,
                                input logic e_shift, input logic e_sample);
        row_t r;
        r.mode = mode; r.cpol = cpol; r.cpha = cpha; r.div = div;
        r.cs = cs; r.ext = ext; r.e_sclk = e_sclk; r.c_sclk = c_sclk;
        r.e_pe = e_pe; r.e_ne = e_ne; r.e_shift = e_shift; r.e_sample = e_sample;
        return r;
    endfunction

    task automatic chk(input string nm, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b expected %0b (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Drive one row, clock once, then compare just after the edge.
    task automatic apply_row(input row_t r, input string tag);
        bus.i_mode     = r.mode;
        bus.i_cpol     = r.cpol;
        bus.i_cpha     = r.cpha;
        bus.i_div      = r.div;
        bus.i_cs       = r.cs;
        bus.i_ext_sclk = r.ext;
        @(posedge clk);
        #1;
        if (r.c_sclk) chk({tag, " sclk"}, bus.o_sclk, r.e_sclk);
        chk({tag, " oe"},     bus.o_sclk_oe,    r.mode);
        chk({tag, " pe"},     bus.o_sclk_pe,    r.e_pe);
        chk({tag, " ne"},     bus.o_sclk_ne,    r.e_ne);
        chk({tag, " shift"},  bus.o_shift_stb,  r.e_shift);
        chk({tag, " sample"}, bus.o_sample_stb, r.e_sample);
    endtask

    initial begin
        logic s, p, n;

        // Idle at cpol=1 right after reset: no strobes.
        for (int i = 0; i < 20; i++) rows.push_back(mk(1,1,0,3'd0,1,0, 1,1, 0,0,0,0));
        for (int i = 0; i < 3; i++)  rows.push_back(mk(1,0,0,3'd0,1,0, 0,1, 0,0,0,0));
        // Leader, div=0: sclk toggles every edge; pe on odd steps, ne on even >= 2.
        for (int k = 0; k <= 16; k++) begin
            s = (k % 2 == 0);
            p = (k % 2 == 1);
            n = (k % 2 == 0) && (k >= 2);
            rows.push_back(mk(1,0,0,3'd0,0,0, s,1, p,n, n,p));
        end
        for (int i = 0; i < 3; i++) rows.push_back(mk(0,0,1,3'd2,1,0, 0,1, 0,0,0,0));
        // Follower, ext 5 high / 5 low, cpha=1 so shift on pe, sample on ne.
        for (int j = 0; j < 20; j++) begin
            p = (j % 10 == 0);
            n = (j % 10 == 5);
            rows.push_back(mk(0,0,1,3'd2,0,((j % 10) < 5), 0,0, p,n, p,n));
        end

        bus.i_mode = 1'b1; bus.i_cpol = 1'b1; bus.i_cpha = 1'b0;
        bus.i_div = 3'd0;  bus.i_cs = 1'b1;   bus.i_ext_sclk = 1'b0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        chk("reset sclk",   bus.o_sclk,       1'b0);
        chk("reset pe",     bus.o_sclk_pe,    1'b0);
        chk("reset ne",     bus.o_sclk_ne,    1'b0);
        chk("reset shift",  bus.o_shift_stb,  1'b0);
        chk("reset sample", bus.o_sample_stb, 1'b0);
        #14 rst_n = 1'b1;

        foreach (rows[i]) apply_row(rows[i], $sformatf("tbl[%0d]", i));

        // div=3, cpol=1, cpha=1; cpol/div changes after k=3 must be ignored.
        for (int i = 0; i < 3; i++) apply_row(mk(1,1,1,3'd3,1,0, 1,1, 0,0,0,0), "A.pre");
        for (int k = 0; k < 40; k++) begin
            s = (((k + 1) / 8) % 2 == 0);
            n = (k == 8) || (k == 24);
            p = (k == 16) || (k == 32);
            if (k >= 3) apply_row(mk(1,0,1,3'd0,0,0, s,1, p,n, n,p), $sformatf("A[%0d]", k));
            else        apply_row(mk(1,1,1,3'd3,0,0, s,1, p,n, n,p), $sformatf("A[%0d]", k));
        end

        // div=2, cs raised mid-half-period, then a clean restart.
        for (int i = 0; i < 3; i++) apply_row(mk(1,0,0,3'd2,1,0, 0,1, 0,0,0,0), "B.pre");
        for (int k = 0; k < 6; k++)
            apply_row(mk(1,0,0,3'd2,0,0, (k >= 3),1, (k == 4),0, 0,(k == 4)), $sformatf("B[%0d]", k));
        for (int i = 0; i < 10; i++) apply_row(mk(1,0,0,3'd2,1,0, 0,1, 0,0,0,0), "B.idle");
        for (int k = 0; k < 5; k++)
            apply_row(mk(1,0,0,3'd2,0,0, (k >= 3),1, (k == 4),0, 0,(k == 4)), $sformatf("B.rs[%0d]", k));

        // div=1 transfer interrupted by an asynchronous reset.
        for (int i = 0; i < 3; i++) apply_row(mk(1,0,0,3'd1,1,0, 0,1, 0,0,0,0), "C.pre");
        for (int k = 0; k < 3; k++)
            apply_row(mk(1,0,0,3'd1,0,0, (k >= 1),1, (k == 2),0, 0,(k == 2)), $sformatf("C[%0d]", k));
        #2 rst_n = 1'b0;
        #1;
        chk("async sclk",   bus.o_sclk,       1'b0);
        chk("async pe",     bus.o_sclk_pe,    1'b0);
        chk("async sample", bus.o_sample_stb, 1'b0);
        bus.i_cs = 1'b1;
        @(posedge clk);
        #2 rst_n = 1'b1;
        apply_row(mk(1,0,0,3'd1,1,0, 0,1, 0,0,0,0), "C.post");
        for (int k = 0; k < 3; k++)
            apply_row(mk(1,0,0,3'd1,0,0, (k >= 1),1, (k == 2),0, 0,(k == 2)), $sformatf("C.rs[%0d]", k));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
